cla_pipelined_adder: RTL

- Parametrised, pipelined add/subtract unit built from 4-bit CLA groups.
- Groups are rippled within a pipeline stage. The carry is registered between stages, and operand and sum skew registers keep each result aligned.
- Valid/ready handshakes on input and output let the unit sit between ALU operand latches and the writeback register.
- Sustains one operation per cycle.

---
 rtl/cla_pipelined_adder_if.sv | 43 ++++
 rtl/cla_pipelined_adder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cla_pipelined_adder_if.sv
// cla_pipelined_adder_if: operand/result handshake bundle for cla_pipelined_adder.
// The producer side (ALU operand latches / testbench) uses the master modport and
// the adder uses the slave modport. Status flags Z, N and V only exist when the
// CLA_STATUS_FLAGS_EN macro is defined.
interface cla_pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C0;
  logic             SUB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             C_OUT;
`ifdef CLA_STATUS_FLAGS_EN
  logic             Z;
  logic             N;
  logic             V;

  modport master (
    output in_valid, A, B, C0, SUB, out_ready,
    input  in_ready, out_valid, S, C_OUT, Z, N, V
  );

  modport slave (
    input  in_valid, A, B, C0, SUB, out_ready,
    output in_ready, out_valid, S, C_OUT, Z, N, V
  );
`else
  modport master (
    output in_valid, A, B, C0, SUB, out_ready,
    input  in_ready, out_valid, S, C_OUT
  );

  modport slave (
    input  in_valid, A, B, C0, SUB, out_ready,
    output in_ready, out_valid, S, C_OUT
  );
`endif
endinterface

// File: rtl/cla_pipelined_adder.sv
// cla_pipelined_adder: pipelined add/subtract unit built from GROUP-bit
// carry-lookahead groups. GPS groups ripple inside each pipeline stage, the
// carry is registered between stages, and skew registers carry the not-yet-added
// operand bits forward alongside the partial sum. One operation per cycle, with
// valid/ready on both sides and a single global advance signal.
// Optional feature: define CLA_STATUS_FLAGS_EN to add registered Z/N/V outputs.
module cla_pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4,
  parameter int GPS   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_pipelined_adder_if.slave bus
);

  localparam int CHUNK  = GROUP * GPS;
  localparam int NSTAGE = WIDTH / CHUNK;

  if (((WIDTH % CHUNK) != 0) || (NSTAGE < 1)) begin : g_bad_params
    $error("cla_pipelined_adder: WIDTH must be a non-zero multiple of GROUP*GPS");
  end

  // One GROUP-bit group with full generate/propagate lookahead: every carry is a
  // flat sum of products of g, p and the group carry-in.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] a,
                                               input logic [GROUP-1:0] b,
                                               input logic             cin);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             term;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = cin;
      for (int m = 0; m <= i; m++) begin
        c[i+1] = c[i+1] & p[m];
      end
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) begin
          term = term & p[m];
        end
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  // One pipeline stage worth of bits: GPS lookahead groups chained by ripple.
  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             cin);
    logic [CHUNK-1:0] s;
    logic             c;
    logic [GROUP:0]   r;
    s = '0;
    c = cin;
    for (int gi = 0; gi < GPS; gi++) begin
      r = cla_group(a[gi*GROUP +: GROUP], b[gi*GROUP +: GROUP], c);
      s[gi*GROUP +: GROUP] = r[GROUP-1:0];
      c = r[GROUP];
    end
    return {c, s};
  endfunction

  logic             adv;

  logic             valid_q   [NSTAGE];
  logic             carry_q   [NSTAGE];
  logic [WIDTH-1:0] sum_q     [NSTAGE];
  logic [WIDTH-1:0] a_q       [NSTAGE];
  logic [WIDTH-1:0] b_q       [NSTAGE];

  logic             src_valid [NSTAGE];
  logic             src_cin   [NSTAGE];
  logic [WIDTH-1:0] src_a     [NSTAGE];
  logic [WIDTH-1:0] src_b     [NSTAGE];
  logic [WIDTH-1:0] src_sum   [NSTAGE];

  logic [CHUNK:0]   chunk_res [NSTAGE];
  logic             nxt_carry [NSTAGE];
  logic [WIDTH-1:0] nxt_sum   [NSTAGE];

  // The whole pipe moves together whenever the output slot is empty or being taken.
  always_comb begin
    adv = !valid_q[NSTAGE-1] || bus.out_ready;
  end

  // Stage 0 reads the bus (with subtract folded into B and carry-in); later stages read the previous stage's registers.
  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      src_valid[k] = 1'b0;
      src_cin[k]   = 1'b0;
      src_a[k]     = '0;
      src_b[k]     = '0;
      src_sum[k]   = '0;
    end
    src_valid[0] = bus.in_valid && adv;
    src_cin[0]   = bus.SUB ? 1'b1 : bus.C0;
    src_a[0]     = bus.A;
    src_b[0]     = bus.SUB ? ~bus.B : bus.B;
    for (int k = 1; k < NSTAGE; k++) begin
      src_valid[k] = valid_q[k-1];
      src_cin[k]   = carry_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_sum[k]   = sum_q[k-1];
    end
  end

  // Each stage adds its own CHUNK-bit slice and splices it into the running sum.
  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      chunk_res[k] = add_chunk(src_a[k][k*CHUNK +: CHUNK],
                               src_b[k][k*CHUNK +: CHUNK],
                               src_cin[k]);
      nxt_sum[k]   = src_sum[k];
      nxt_sum[k][k*CHUNK +: CHUNK] = chunk_res[k][CHUNK-1:0];
      nxt_carry[k] = chunk_res[k][CHUNK];
    end
  end

  // Stage registers: shift on advance, a bubble clears valid but leaves the data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGE; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < NSTAGE; k++) begin
        valid_q[k] <= src_valid[k];
        if (src_valid[k]) begin
          carry_q[k] <= nxt_carry[k];
          sum_q[k]   <= nxt_sum[k];
          a_q[k]     <= src_a[k];
          b_q[k]     <= src_b[k];
        end
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[NSTAGE-1];
  assign bus.S         = sum_q[NSTAGE-1];
  assign bus.C_OUT     = carry_q[NSTAGE-1];

`ifdef CLA_STATUS_FLAGS_EN
  logic z_q;
  logic n_q;
  logic v_q;
  logic z_d;
  logic n_d;
  logic v_d;

  // Flags come from the final sum and the operand sign bits carried down the skew path.
  always_comb begin
    z_d = (nxt_sum[NSTAGE-1] == '0);
    n_d = nxt_sum[NSTAGE-1][WIDTH-1];
    v_d = (src_a[NSTAGE-1][WIDTH-1] == src_b[NSTAGE-1][WIDTH-1]) &&
          (nxt_sum[NSTAGE-1][WIDTH-1] != src_a[NSTAGE-1][WIDTH-1]);
  end

  // Flag registers follow the same load/hold rules as S.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else if (adv && src_valid[NSTAGE-1]) begin
      z_q <= z_d;
      n_q <= n_d;
      v_q <= v_d;
    end
  end

  assign bus.Z = z_q;
  assign bus.N = n_q;
  assign bus.V = v_q;
`endif

endmodule
